// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and operand-signedness helpers for the M-extension unit.
package muldiv_pkg;

  // funct3 encodings of the M-extension ops
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // Control FSM states
  typedef enum logic [2:0] {
    MDS_IDLE = 3'd0,
    MDS_MUL  = 3'd1,
    MDS_FAST = 3'd2,
    MDS_DIV  = 3'd3,
    MDS_DFIX = 3'd4,
    MDS_DONE = 3'd5
  } md_state_e;

  // rs1 is treated as two's complement
  function automatic logic is_signed_a(input md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as two's complement
  function automatic logic is_signed_b(input md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // op produces the remainder rather than the quotient
  function automatic logic is_rem(input md_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done_c,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [CW-1:0]   cnt;
  logic            run;
  logic [XLEN:0]   partial;
  logic [XLEN:0]   diff;

  // Partial remainder shifted with the next dividend bit, and trial subtraction
  assign partial = {rem, quo[XLEN-1]};
  assign diff    = partial - {1'b0, dvs};

  // Iteration: dividend bits shift out of quo as quotient bits shift in
  always_ff @(posedge clock) begin
    if (reset || kill) begin
      run <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(XLEN - 1);
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (run) begin
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= partial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - CW'(1);
    end
  end

  assign done_c    = run && (cnt == '0);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV M-extension multiply/divide unit with valid/ready handshake and flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned   PW   = 2 * XLEN;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e        state;
  md_op_e           op_q;
  md_op_e           in_op_e;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [TAG_W-1:0] tag_q;
  logic             first;
  logic [PW-1:0]    prod_q;

  logic [PW-1:0]    ext_a;
  logic [PW-1:0]    ext_b;
  logic [PW-1:0]    mul_full;
  logic [XLEN-1:0]  mul_sel;
  logic             neg_a;
  logic             neg_b;
  logic [XLEN-1:0]  mag_a;
  logic [XLEN-1:0]  mag_b;
  logic             corner_c;
  logic [XLEN-1:0]  fast_res;
  logic [XLEN-1:0]  fix_res;
  logic             div_start;
  logic             div_done;
  logic [XLEN-1:0]  div_q;
  logic [XLEN-1:0]  div_r;

  assign in_op_e  = md_op_e'(in_op);
  assign in_ready = (state == MDS_IDLE);
  assign busy     = (state != MDS_IDLE);

  // Divide-by-zero and signed overflow bypass the iterative divider
  assign corner_c = (in_b == '0) ||
                    (is_signed_b(in_op_e) && (in_a == MINV) && (in_b == ONES));

  // Multiplier on sign/zero-extended operands; product kept at full width
  assign ext_a    = is_signed_a(op_q) ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
  assign ext_b    = is_signed_b(op_q) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
  assign mul_full = ext_a * ext_b;
  assign mul_sel  = (op_q == MD_MUL) ? prod_q[XLEN-1:0] : prod_q[PW-1:XLEN];

  // Operand magnitudes for the divider; MINV magnitude fits as unsigned
  assign neg_a = is_signed_a(op_q) & a_q[XLEN-1];
  assign neg_b = is_signed_b(op_q) & b_q[XLEN-1];
  assign mag_a = neg_a ? -a_q : a_q;
  assign mag_b = neg_b ? -b_q : b_q;

  // Corner-case results: x/0 and MINV/-1
  assign fast_res = (b_q == '0) ? (is_rem(op_q) ? a_q : ONES)
                                : (is_rem(op_q) ? '0  : a_q);

  // Sign fix-up: quotient negative on differing signs, remainder follows dividend
  assign fix_res = is_rem(op_q) ? (neg_a ? -div_r : div_r)
                                : ((neg_a ^ neg_b) ? -div_q : div_q);

  assign div_start = (state == MDS_DIV) && first;

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clock     (clock),
    .reset     (reset),
    .kill      (flush),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done_c    (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Control FSM, operand capture and registered result/handshake outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= MDS_IDLE;
      op_q       <= MD_MUL;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      first      <= 1'b0;
      prod_q     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= MDS_IDLE;
      first     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        MDS_IDLE: begin
          if (in_valid) begin
            op_q  <= in_op_e;
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
            first <= 1'b1;
            if (!in_op[2])     state <= MDS_MUL;
            else if (corner_c) state <= MDS_FAST;
            else               state <= MDS_DIV;
          end
        end
        MDS_MUL: begin
          first <= 1'b0;
          if (first) begin
            prod_q <= mul_full;
          end else begin
            out_result <= mul_sel;
            out_tag    <= tag_q;
            out_valid  <= 1'b1;
            state      <= MDS_DONE;
          end
        end
        MDS_FAST: begin
          // first cycle lets short ops share the multiply latency
          first <= 1'b0;
          if (!first) begin
            out_result <= fast_res;
            out_tag    <= tag_q;
            out_valid  <= 1'b1;
            state      <= MDS_DONE;
          end
        end
        MDS_DIV: begin
          first <= 1'b0;
          if (div_done) state <= MDS_DFIX;
        end
        MDS_DFIX: begin
          out_result <= fix_res;
          out_tag    <= tag_q;
          out_valid  <= 1'b1;
          state      <= MDS_DONE;
        end
        MDS_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= MDS_IDLE;
          end
        end
        default: state <= MDS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops, latency, backpressure, flush and reset.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'b000;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Issue one request; accept edge k is the edge_n seen 1ns after it
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] exp, input int lat,
                      input bit track, input string name);
    @(negedge clock);
    chk({name, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_op    = 3'b000;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h0;
    in_tag   = 5'h1F;
    if (track) sb.push_back('{exp, tag, edge_n + lat, name});
    chk({name, ".busy"}, 64'(busy), 64'd1);
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (sb.size() == 0 && in_ready && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, ".drain"}, 64'(ok), 64'd1);
  endtask

  // Monitor: compare the scoreboard head on each new result, including its arrival edge
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got result %0h, want no result", out_result);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".result"}, 64'(out_result), 64'(e.res));
          chk({e.name, ".tag"}, 64'(out_tag), 64'(e.tag));
          chk({e.name, ".edge"}, 64'(edge_n), 64'(e.due));
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_result", 64'(out_result), 64'd0);
    chk("rst.out_tag", 64'(out_tag), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    // MUL with ready low through MUL and DONE
    send(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB, 2, 1'b1, "mul");
    chk("mul.in_ready_k", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    chk("mul.in_ready_k1", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    chk("mul.in_ready_done", 64'(in_ready), 64'd0);
    drain("mul");

    // High multiplies
    send(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 2, 1'b1, "mulh");
    drain("mulh");
    send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2, 1'b1, "mulhu");
    drain("mulhu");
    send(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 2, 1'b1, "mulhsu");
    drain("mulhsu");

    // Iterative divides
    send(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34, 1'b1, "div_m7_2");
    drain("div_m7_2");
    send(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34, 1'b1, "rem_m7_2");
    drain("rem_m7_2");
    send(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC, 34, 1'b1, "divu");
    drain("divu");
    send(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'hFFFF_FFF2, 34, 1'b1, "div_100_m7");
    drain("div_100_m7");
    send(3'b110, 32'd100, 32'hFFFF_FFF9, 5'd9, 32'd2, 34, 1'b1, "rem_100_m7");
    drain("rem_100_m7");

    // Corner cases take the short path
    send(3'b101, 32'd100, 32'd0, 5'd10, 32'hFFFF_FFFF, 2, 1'b1, "divu_by0");
    drain("divu_by0");
    send(3'b111, 32'd100, 32'd0, 5'd11, 32'd100, 2, 1'b1, "remu_by0");
    drain("remu_by0");
    send(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2, 1'b1, "div_ovf");
    drain("div_ovf");
    send(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 2, 1'b1, "rem_ovf");
    drain("rem_ovf");
    send(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd14, 32'hFFFF_FFFB, 2, 1'b1, "rem_by0");
    drain("rem_by0");

    // Backpressure: result held in DONE, then back-to-back MUL
    out_ready = 1'b0;
    send(3'b000, 32'd6, 32'd7, 5'd9, 32'd42, 2, 1'b1, "bp");
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.hold_result", 64'(out_result), 64'd42);
      chk("bp.hold_tag", 64'(out_tag), 64'd9);
      chk("bp.hold_valid", 64'(out_valid), 64'd1);
      chk("bp.hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp.taken_valid", 64'(out_valid), 64'd0);
    chk("bp.taken_in_ready", 64'(in_ready), 64'd1);
    send(3'b000, 32'd3, 32'd4, 5'd1, 32'd12, 2, 1'b1, "b2b");
    drain("b2b");

    // Flush at cycle 10 of a DIV
    send(3'b100, 32'd1000, 32'd3, 5'd7, 32'd0, 34, 1'b0, "fl_div");
    repeat (9) @(posedge clock);
    #1;
    chk("fl.busy_before", 64'(busy), 64'd1);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("fl.busy_after", 64'(busy), 64'd0);
    chk("fl.valid_after", 64'(out_valid), 64'd0);
    repeat (40) @(posedge clock);
    #1;
    chk("fl.no_result", 64'(out_valid), 64'd0);
    send(3'b000, 32'd3, 32'd5, 5'd2, 32'd15, 2, 1'b1, "fl_mul");
    drain("fl_mul");

    // Flush beats a simultaneous request in IDLE
    @(negedge clock);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 3'b000;
    in_a     = 32'd2;
    in_b     = 32'd2;
    @(posedge clock); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_idle.busy", 64'(busy), 64'd0);
    chk("fl_idle.in_ready", 64'(in_ready), 64'd1);
    repeat (4) @(posedge clock);
    #1;
    chk("fl_idle.no_result", 64'(out_valid), 64'd0);

    // Reset in the middle of a DIV
    send(3'b101, 32'd12345, 32'd7, 5'd3, 32'd0, 34, 1'b0, "rst_div");
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid.out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid.out_result", 64'(out_result), 64'd0);
    chk("rst_mid.out_tag", 64'(out_tag), 64'd0);
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("rst_mid.no_result", 64'(out_valid), 64'd0);
    chk("final.sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
